// File: rtl/sysid_checker.sv
`default_nettype none
// ============================================================================
// Module      : sysid_checker
// Description : Avalon-MM read master that fetches the system ID (word 0) and
//               the build timestamp (word 1) from a system ID slave, registers
//               both words and flags whether each equals its expected value.
//               A check runs on a start pulse or, optionally, once
//               automatically after reset.
// Ports       :
//   clock           in   system clock, rising edge
//   reset           in   asynchronous active-high reset
//   start           in   single-cycle check request (ignored while busy)
//   address         out  slave word address (0 = ID, 1 = timestamp)
//   read            out  Avalon read strobe
//   readdata        in   slave read data (32 bits)
//   busy            out  check in progress
//   done            out  check complete (level, until next start/reset)
//   id_match        out  captured ID equals EXPECTED_ID
//   ts_match        out  captured timestamp equals EXPECTED_TIMESTAMP
//   id_value        out  captured ID word
//   timestamp_value out  captured timestamp word
// Revision    : 1.0 - initial release
// ============================================================================
module sysid_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1561695745,
   parameter int          READ_LATENCY       = 0,
   parameter int          AUTO_START         = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        address,
   output logic        read,
   input  logic [31:0] readdata,
   output logic        busy,
   output logic        done,
   output logic        id_match,
   output logic        ts_match,
   output logic [31:0] id_value,
   output logic [31:0] timestamp_value
);

   // Last latency count of each read; readdata is valid on that edge.
   localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RD_ID = 2'd1,
      S_RD_TS = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [2:0] lat_cnt;
   logic [2:0] lat_next;
   logic       auto_pending;
   logic       launch;
   logic       capture_id;
   logic       capture_ts;
   logic       lat_last;

   assign lat_last = (lat_cnt == LAT_LAST);

   // ------------------------------------------------------------------------
   // Next-state and output decode. address/read/busy depend only on
   // registered state and lat_cnt, so they are glitch-free decodes.
   // ------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      lat_next   = lat_cnt;
      address    = 1'b0;
      read       = 1'b0;
      busy       = 1'b0;
      launch     = 1'b0;
      capture_id = 1'b0;
      capture_ts = 1'b0;

      case (state)
         S_IDLE, S_DONE: begin
            if (start || auto_pending) begin
               launch     = 1'b1;
               state_next = S_RD_ID;
               lat_next   = 3'd0;
            end
         end
         S_RD_ID: begin
            busy    = 1'b1;
            address = 1'b0;
            // Strobe only on the first cycle; the rest is slave latency.
            read    = (lat_cnt == 3'd0);
            if (lat_last) begin
               capture_id = 1'b1;
               lat_next   = 3'd0;
               state_next = S_RD_TS;
            end else begin
               lat_next   = lat_cnt + 3'd1;
            end
         end
         S_RD_TS: begin
            busy    = 1'b1;
            address = 1'b1;
            read    = (lat_cnt == 3'd0);
            if (lat_last) begin
               capture_ts = 1'b1;
               lat_next   = 3'd0;
               state_next = S_DONE;
            end else begin
               lat_next   = lat_cnt + 3'd1;
            end
         end
         default: begin
            state_next = S_IDLE;
            lat_next   = 3'd0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         lat_cnt <= 3'd0;
      end else begin
         state   <= state_next;
         lat_cnt <= lat_next;
      end
   end

   // ------------------------------------------------------------------------
   // Captured words and status. id_match is evaluated from the already
   // registered id_value; ts_match compares readdata directly so both flags
   // land on the same edge as done.
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         auto_pending    <= (AUTO_START != 0);
         done            <= 1'b0;
         id_match        <= 1'b0;
         ts_match        <= 1'b0;
         id_value        <= 32'd0;
         timestamp_value <= 32'd0;
      end else begin
         if (launch) begin
            auto_pending <= 1'b0;
            done         <= 1'b0;
            id_match     <= 1'b0;
            ts_match     <= 1'b0;
         end
         if (capture_id) begin
            id_value <= readdata;
         end
         if (capture_ts) begin
            timestamp_value <= readdata;
            id_match        <= (id_value == EXPECTED_ID);
            ts_match        <= (readdata == EXPECTED_TIMESTAMP);
            done            <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sysid_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_sysid_checker
// Description : Self-checking bench for sysid_checker. Three instances:
//               0: latency 0, auto start, default expected values
//               1: latency 3, auto start, non-default expected ID
//               2: latency 2, no auto start
//               Each has a behavioural slave that returns its word only on
//               the cycle the master should capture it and random junk
//               otherwise. Expected results come from the slave contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sysid_checker;

   localparam logic [31:0] TS_EXP = 32'd1561695745;

   function automatic int lat_of(input int i);
      return (i == 0) ? 0 : (i == 1) ? 3 : 2;
   endfunction

   function automatic logic [31:0] id_exp_of(input int i);
      return (i == 1) ? 32'h1234_5678 : 32'd0;
   endfunction

   function automatic int auto_of(input int i);
      return (i == 2) ? 0 : 1;
   endfunction

   logic        clk = 1'b0;
   logic        rst      [3];
   logic        start    [3];
   logic        addr     [3];
   logic        rd       [3];
   logic        busy     [3];
   logic        done     [3];
   logic        idm      [3];
   logic        tsm      [3];
   logic [31:0] rdata    [3];
   logic [31:0] idv      [3];
   logic [31:0] tsv      [3];
   logic [31:0] mem      [3][2];
   logic [31:0] last_id  [3];
   logic [31:0] last_ts  [3];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_inst
      localparam int L = lat_of(g);
      logic [31:0] junk  = 32'hDEAD_BEEF;
      logic [7:0]  h_rd  = 8'd0;
      logic [7:0]  h_ad  = 8'd0;

      always @(negedge clk) junk <= $urandom;

      // History of (read, address) per cycle, newest in bit 0.
      always @(posedge clk) begin
         h_rd <= {h_rd[6:0], rd[g]};
         h_ad <= {h_ad[6:0], addr[g]};
      end

      if (L == 0) begin : g_comb
         assign rdata[g] = rd[g] ? mem[g][addr[g]] : junk;
      end else begin : g_dly
         assign rdata[g] = h_rd[L-1] ? mem[g][h_ad[L-1]] : junk;
      end

      sysid_checker #(
         .EXPECTED_ID       (id_exp_of(g)),
         .EXPECTED_TIMESTAMP(TS_EXP),
         .READ_LATENCY      (L),
         .AUTO_START        (auto_of(g))
      ) u_dut (
         .clock          (clk),
         .reset          (rst[g]),
         .start          (start[g]),
         .address        (addr[g]),
         .read           (rd[g]),
         .readdata       (rdata[g]),
         .busy           (busy[g]),
         .done           (done[g]),
         .id_match       (idm[g]),
         .ts_match       (tsm[g]),
         .id_value       (idv[g]),
         .timestamp_value(tsv[g])
      );
   end

   task automatic check_value(input string tag, input logic [63:0] got,
                              input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag, input int i);
      check_value({tag, "_ctrl"},
                  {58'd0, addr[i], rd[i], busy[i], done[i], idm[i], tsm[i]}, 64'd0);
      check_value({tag, "_data"}, {idv[i], tsv[i]}, 64'd0);
   endtask

   task automatic pick_mem(input int i);
      mem[i][0] = ($urandom_range(0, 1) == 1) ? id_exp_of(i) : $urandom;
      mem[i][1] = ($urandom_range(0, 1) == 1) ? TS_EXP       : $urandom;
   endtask

   // Runs one check from the current negedge and compares against the model:
   // one read per word, busy for 2*(L+1) cycles, done after 2*(L+1) edges,
   // words taken from the slave, matches from plain equality.
   task automatic run_check(input int i, input bit via_start, input bit poke);
      int          L       = lat_of(i);
      int          cyc     = 0;
      int          nrd0    = 0;
      int          nrd1    = 0;
      int          nbusy   = 0;
      int          done_at = -1;
      int          qbusy   = 0;
      int          qlow    = 0;
      logic [31:0] e_id    = mem[i][0];
      logic [31:0] e_ts    = mem[i][1];
      if (via_start) start[i] = 1'b1;
      while (done_at < 0 && cyc < 64) begin
         @(negedge clk);
         start[i] = 1'b0;
         cyc++;
         if (poke && cyc == L + 2) start[i] = 1'b1;
         if (cyc == 1) begin
            check_value("run_done_cleared", done[i], 0);
            check_value("run_id_kept", idv[i], last_id[i]);
            check_value("run_ts_kept", tsv[i], last_ts[i]);
         end
         if (rd[i]) begin
            if (addr[i]) nrd1++;
            else nrd0++;
         end
         if (busy[i]) nbusy++;
         if (done[i]) done_at = cyc;
      end
      start[i] = 1'b0;
      check_value("done_edges", done_at - 1, 2 * (L + 1));
      check_value("reads_addr0", nrd0, 1);
      check_value("reads_addr1", nrd1, 1);
      check_value("busy_cycles", nbusy, 2 * (L + 1));
      check_value("id_value", idv[i], e_id);
      check_value("ts_value", tsv[i], e_ts);
      check_value("id_match", idm[i], (e_id == id_exp_of(i)));
      check_value("ts_match", tsm[i], (e_ts == TS_EXP));
      repeat (2 * L + 4) begin
         @(negedge clk);
         if (busy[i] || rd[i]) qbusy++;
         if (!done[i]) qlow++;
      end
      check_value("quiet_busy", qbusy, 0);
      check_value("done_hold", qlow, 0);
      last_id[i] = e_id;
      last_ts[i] = e_ts;
   endtask

   // start held high from DONE: one run per 2*(L+1)+1 cycles, done one cycle.
   task automatic held_start(input int i);
      int L      = lat_of(i);
      int per    = 2 * L + 3;
      int nd     = 0;
      int run    = 0;
      int maxrun = 0;
      start[i] = 1'b1;
      repeat (3 * per) begin
         @(negedge clk);
         if (done[i]) begin
            nd++;
            run++;
         end else begin
            run = 0;
         end
         if (run > maxrun) maxrun = run;
      end
      start[i] = 1'b0;
      check_value("held_done_count", nd, 3);
      check_value("held_done_width", maxrun, 1);
      check_value("held_id_value", idv[i], mem[i][0]);
      last_id[i] = mem[i][0];
      last_ts[i] = mem[i][1];
   endtask

   initial begin
      int idle_act;
      for (int i = 0; i < 3; i++) begin
         rst[i]     = 1'b1;
         start[i]   = 1'b0;
         last_id[i] = 32'd0;
         last_ts[i] = 32'd0;
         mem[i][0]  = 32'd0;
         mem[i][1]  = 32'd0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) check_all_zero("reset", i);

      // Instance 0: auto check with the nominal slave contents.
      mem[0][0] = 32'd0;
      mem[0][1] = TS_EXP;
      rst[0] = 1'b0;
      run_check(0, 1'b0, 1'b0);
      // Wrong timestamp build.
      mem[0][1] = 32'h5D14_0001;
      run_check(0, 1'b1, 1'b0);
      // Random contents, including a start during RD_TS that must be ignored.
      for (int k = 0; k < 4; k++) begin
         pick_mem(0);
         run_check(0, 1'b1, (k == 1));
      end
      pick_mem(0);
      held_start(0);

      // Instance 1: latency 3, auto check then start-driven checks.
      pick_mem(1);
      rst[1] = 1'b0;
      run_check(1, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         pick_mem(1);
         run_check(1, 1'b1, (k == 2));
      end
      // Reset in the middle of the RD_ID latency window.
      pick_mem(1);
      start[1] = 1'b1;
      repeat (2) begin
         @(negedge clk);
         start[1] = 1'b0;
      end
      check_value("pre_abort_busy", busy[1], 1);
      #2 rst[1] = 1'b1;
      #1 check_all_zero("async_abort", 1);
      @(negedge clk);
      rst[1]     = 1'b0;
      last_id[1] = 32'd0;
      last_ts[1] = 32'd0;
      mem[1][0]  = id_exp_of(1);
      mem[1][1]  = TS_EXP;
      run_check(1, 1'b0, 1'b0);

      // Instance 2: no auto start, nothing happens until start.
      rst[2] = 1'b0;
      idle_act = 0;
      repeat (10) begin
         @(negedge clk);
         if (rd[2] || busy[2] || done[2]) idle_act++;
      end
      check_value("no_auto_activity", idle_act, 0);
      for (int k = 0; k < 3; k++) begin
         pick_mem(2);
         run_check(2, 1'b1, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
